// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants, state type and one-hot helper for the mux round-robin arbiter
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam logic [3:0] MAX_BURST_DEF = 4'd8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rtl/mux_rr_arbiter_rr_pick.sv - combinational round-robin picker, scans from ptr+1 upward with wrap
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] cand;
  logic [SEL_W-1:0] cand_idx;

  // Walk farthest-to-nearest so the nearest candidate after ptr is the last write.
  always_comb begin
    cand     = req & ~mask;
    found    = 1'b0;
    idx      = ptr;
    cand_idx = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      cand_idx = ptr + SEL_W'(k);
      if (cand[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving the 4:1 mux select and one-hot grant
// Optional burst limit enabled by defining MUX_ARB_BURST_LIMIT_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
`ifdef MUX_ARB_BURST_LIMIT_EN
#(
  parameter logic [3:0] MAX_BURST = MAX_BURST_DEF
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             gnt_chg
);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             chg_q, chg_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [N_REQ-1:0] pick_mask;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             owner_req;
  logic             force_rot;

`ifdef MUX_ARB_BURST_LIMIT_EN
  logic [3:0]       cnt_q, cnt_d;
`endif

  // While granted, the owner is masked so found means another requester is waiting.
  assign pick_mask = (state_q == GRANT) ? grant_q : '0;
  assign owner_req = |(req & grant_q);

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef MUX_ARB_BURST_LIMIT_EN
  assign force_rot = (cnt_q == MAX_BURST) && pick_found;
`else
  assign force_rot = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    chg_d   = 1'b0;
    ptr_d   = ptr_q;
`ifdef MUX_ARB_BURST_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          grant_d = onehot(pick_idx);
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          chg_d   = 1'b1;
          ptr_d   = pick_idx;
`ifdef MUX_ARB_BURST_LIMIT_EN
          cnt_d   = 4'd1;
`endif
        end
      end
      GRANT: begin
        if (owner_req && !force_rot) begin
`ifdef MUX_ARB_BURST_LIMIT_EN
          cnt_d = (cnt_q >= MAX_BURST) ? MAX_BURST : cnt_q + 4'd1;
`endif
        end else if (pick_found) begin
          grant_d = onehot(pick_idx);
          sel_d   = pick_idx;
          chg_d   = 1'b1;
          ptr_d   = pick_idx;
`ifdef MUX_ARB_BURST_LIMIT_EN
          cnt_d   = 4'd1;
`endif
        end else begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ptr resets to the last index so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      chg_q   <= 1'b0;
      ptr_q   <= SEL_W'(N_REQ - 1);
`ifdef MUX_ARB_BURST_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      chg_q   <= chg_d;
      ptr_q   <= ptr_d;
`ifdef MUX_ARB_BURST_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign gnt_chg = chg_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter; expected word is {grant, sel, busy, gnt_chg}
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       gnt_chg;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

`ifdef MUX_ARB_BURST_LIMIT_EN
  mux_rr_arbiter #(.MAX_BURST(4'd3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant), .sel(sel), .busy(busy), .gnt_chg(gnt_chg)
  );
`else
  mux_rr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant), .sel(sel), .busy(busy), .gnt_chg(gnt_chg)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycle(input logic rn, input logic [3:0] r);
    @(negedge clk);
    rst_n = rn;
    req   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 4'b0000);
    cycle(1'b0, 4'b0000);
  endtask

  task automatic test_reset();
    logic [3:0] rq [3] = '{4'b1111, 4'b1111, 4'b0000};
    logic       rn [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] got, e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'b0000_00_0_0);
      cycle(rn[i], rq[i]);
      got = {grant, sel, busy, gnt_chg};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset[%0d] got=%b expected=%b", i, got, e);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] rq [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic [7:0] ex [4] = '{8'b0001_00_1_1, 8'b0001_00_1_0, 8'b0000_00_0_0, 8'b0000_00_0_0};
    logic [7:0] got, e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ex[i]);
      cycle(1'b1, rq[i]);
      got = {grant, sel, busy, gnt_chg};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL single[%0d] got=%b expected=%b", i, got, e);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] rq [9] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                           4'b1111, 4'b1011, 4'b1111, 4'b0111};
    logic [7:0] ex [9] = '{8'b0001_00_1_1, 8'b0001_00_1_0, 8'b0010_01_1_1,
                           8'b0010_01_1_0, 8'b0100_10_1_1, 8'b0100_10_1_0,
                           8'b1000_11_1_1, 8'b1000_11_1_0, 8'b0001_00_1_1};
    logic [7:0] got, e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      sb.push_back(ex[i]);
      cycle(1'b1, rq[i]);
      got = {grant, sel, busy, gnt_chg};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rotation[%0d] got=%b expected=%b", i, got, e);
      end
    end
  endtask

  task automatic test_ptr_priority();
    logic [3:0] rq [4] = '{4'b0010, 4'b0000, 4'b0101, 4'b0000};
    logic [7:0] ex [4] = '{8'b0010_01_1_1, 8'b0000_01_0_0, 8'b0100_10_1_1, 8'b0000_10_0_0};
    logic [7:0] got, e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ex[i]);
      cycle(1'b1, rq[i]);
      got = {grant, sel, busy, gnt_chg};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL ptr_priority[%0d] got=%b expected=%b", i, got, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] rq [4] = '{4'b1000, 4'b0011, 4'b0010, 4'b0000};
    logic [7:0] ex [4] = '{8'b1000_11_1_1, 8'b0001_00_1_1, 8'b0010_01_1_1, 8'b0000_01_0_0};
    logic [7:0] got, e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ex[i]);
      cycle(1'b1, rq[i]);
      got = {grant, sel, busy, gnt_chg};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL wrap[%0d] got=%b expected=%b", i, got, e);
      end
    end
  endtask

  task automatic test_burst();
`ifdef MUX_ARB_BURST_LIMIT_EN
    logic [7:0] ex [10] = '{8'b0001_00_1_1, 8'b0001_00_1_0, 8'b0001_00_1_0,
                            8'b0010_01_1_1, 8'b0010_01_1_0, 8'b0010_01_1_0,
                            8'b0001_00_1_1, 8'b0001_00_1_0, 8'b0001_00_1_0,
                            8'b0010_01_1_1};
`else
    logic [7:0] ex [10] = '{8'b0001_00_1_1, 8'b0001_00_1_0, 8'b0001_00_1_0,
                            8'b0001_00_1_0, 8'b0001_00_1_0, 8'b0001_00_1_0,
                            8'b0001_00_1_0, 8'b0001_00_1_0, 8'b0001_00_1_0,
                            8'b0001_00_1_0};
`endif
    logic [7:0] got, e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sb.push_back(ex[i]);
      cycle(1'b1, 4'b0011);
      got = {grant, sel, busy, gnt_chg};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL burst[%0d] got=%b expected=%b", i, got, e);
      end
    end
  endtask

  task automatic test_burst_saturate();
    logic [3:0] rq [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0011};
`ifdef MUX_ARB_BURST_LIMIT_EN
    logic [7:0] ex [7] = '{8'b0001_00_1_1, 8'b0001_00_1_0, 8'b0001_00_1_0, 8'b0001_00_1_0,
                           8'b0001_00_1_0, 8'b0010_01_1_1, 8'b0010_01_1_0};
`else
    logic [7:0] ex [7] = '{8'b0001_00_1_1, 8'b0001_00_1_0, 8'b0001_00_1_0, 8'b0001_00_1_0,
                           8'b0001_00_1_0, 8'b0001_00_1_0, 8'b0001_00_1_0};
`endif
    logic [7:0] got, e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sb.push_back(ex[i]);
      cycle(1'b1, rq[i]);
      got = {grant, sel, busy, gnt_chg};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL burst_saturate[%0d] got=%b expected=%b", i, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    logic       rn [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] rq [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic [7:0] ex [5] = '{8'b0100_10_1_1, 8'b0100_10_1_0, 8'b0000_00_0_0,
                           8'b0100_10_1_1, 8'b0000_10_0_0};
    logic [7:0] got, e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sb.push_back(ex[i]);
      cycle(rn[i], rq[i]);
      got = {grant, sel, busy, gnt_chg};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid_grant[%0d] got=%b expected=%b", i, got, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_ptr_priority();
    test_wrap();
    test_burst();
    test_burst_saturate();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the 4:1 single-bit multiplexer among four requesters.
- Drives the mux 2-bit select (sel[1] to the upper select input, sel[0] to the lower) and a one-hot grant back to the requesters.
- Sits directly in front of the mux; the mux itself is unchanged.

Parameters:
- N_REQ, 4, number of requesters; fixed at 4 to match the mux, any other value is unsupported.
- MAX_BURST, 8, maximum consecutive grant cycles before forced rotation; used only with the optional feature; legal range 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- req  input  4  request vector; bit i = requester i wants the mux.
- grant  output  4  registered one-hot grant; all-zero when idle.
- sel  output  2  registered binary index of current owner, wired to the mux select.
- busy  output  1  registered; 1 while any grant is active.
- gnt_chg  output  1  one-cycle pulse on every cycle where grant changed to a new non-zero owner.

Behaviour:
- Reset (rst_n=0 at an edge): grant=0000, sel=00, busy=0, gnt_chg=0, state=IDLE, last-owner pointer=3 (requester 0 gets first priority). Reset mid-grant drops the grant at that edge.
- States: IDLE, GRANT.
- IDLE: if req != 0 at an edge, pick the winner as the first set bit scanning from (ptr+1) mod 4 upward with wrap. Next cycle: grant=onehot(winner), sel=winner, busy=1, gnt_chg=1, ptr=winner, state=GRANT. If req == 0, stay in IDLE with outputs 0.
- GRANT, owner request still high: grant held and gnt_chg=0. Without the optional feature, the owner keeps the mux indefinitely.
- GRANT, owner request low, others pending: pick a new winner from (owner+1) with wrap. Switch in the next cycle with no dead cycle, gnt_chg=1, ptr updated.
- GRANT, owner request low, none pending: return to IDLE; next cycle grant=0, busy=0, sel holds its last value.
- Latency: request to grant is 1 clock from idle. Release to handover is 1 clock.
- grant is always one-hot or zero. sel always matches the grant index when busy=1.
- Simultaneous requests are resolved purely by round-robin order from ptr. A requester that drops and re-raises req in the same cycle as a handover is treated as any other requester.

Optional Feature:
- Macro: MUX_ARB_BURST_LIMIT_EN.
- Defined:
  - A 4-bit burst counter loads 1 on each new grant and increments each held cycle, saturating at MAX_BURST.
  - When count==MAX_BURST and another requester is pending, the grant rotates to the next requester at that edge even if the owner's req is high.
  - If no other requester is pending, the owner keeps the grant and the counter stays at MAX_BURST.
  - A reset clears the counter.
- Undefined: no counter logic exists; the grant is held until the owner releases.

Decomposition:
- Shared package mux_arb_pkg:
  - N_REQ=4 and SEL_W=2.
  - State typedef (IDLE, GRANT).
  - MAX_BURST default constant.
- One natural sub-module, rr_pick: combinational round-robin picker. Inputs: req[3:0], ptr[1:0], mask of the current owner. Outputs: found and idx[1:0].
- The state machine, registers and burst counter live in mux_rr_arbiter.

Test Plan:
- Reset then req=0001 → next cycle grant=0001, sel=00, busy=1, gnt_chg=1.
- Owner 0 holding; req goes 0000 → next cycle grant=0000, busy=0, sel stays 00.
- From reset, req=1111 held, each owner drops its bit for one cycle after 2 cycles → grant order 0001,0010,0100,1000,0001, no idle cycles between owners.
- ptr=1 (last owner 1), idle, req=0101 → grant=0100 (requester 2 before 0).
- MUX_ARB_BURST_LIMIT_EN, MAX_BURST=3, req=0011 held constant → grant 0001 for 3 cycles, then 0010 for 3, then back to 0001. Without the macro, grant stays 0001.
- rst_n=0 asserted while grant=0100 → the next edge gives grant=0000 and sel=00. After release with req=0100, grant=0100 returns after 1 cycle.
